valid_clear_seq: RTL and testbench

Flash-clear sequencer for a cache's 256-entry valid-bit array, placed directly upstream of the valid-bit memory. The valid-bit memory has no hardware clear, so after reset, and on an explicit flush, this block sweeps every index and writes 0. While it sweeps, it stalls the cache controller. Outside a sweep it passes controller accesses straight through to the memory.

---
 rtl/valid_clear_seq.sv | 121 ++++++++++++
 tb/tb_valid_clear_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/valid_clear_seq.sv
// valid_clear_seq
// Flash-clear sequencer for a cache valid-bit array. The valid-bit memory has
// no hardware clear, so after reset and on a flush request this block walks
// every index writing 0 while holding the cache controller off with busy.
// Outside a sweep, controller accesses pass straight through to the memory
// with zero added latency.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   flush       single-cycle request to invalidate all entries
//   c_addr      controller index
//   c_write     controller write enable
//   c_data_in   controller write data
//   c_data_out  valid bit returned to the controller (0 while busy)
//   busy        sweep in progress; controller must hold its request
//   clear_done  one-cycle pulse on the final sweep cycle
//   m_addr      index to the valid-bit memory
//   m_write     write enable to the valid-bit memory
//   m_data_in   write data to the valid-bit memory
//   m_data_out  combinational read data from the valid-bit memory
//
// DEPTH must equal 2**ADDR_W.

module valid_clear_seq #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic              c_write,
    input  logic              c_data_in,
    output logic              c_data_out,
    output logic              busy,
    output logic              clear_done,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_write,
    output logic              m_data_in,
    input  logic              m_data_out
);

    typedef enum logic {
        StClear,
        StPass
    } state_e;

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              last_idx;

    assign last_idx = (cnt_q == LastIdx);

    // Next-state logic. flush during a sweep is ignored: the sweep already
    // covers every entry and no controller write can land meanwhile.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StClear: begin
                if (last_idx) begin
                    state_d = StPass;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StPass: begin
                if (flush) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StClear;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StClear;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are decoded from state, cnt and the inputs. Writes are gated by
    // rst so no edge while reset is held can touch the memory.
    always_comb begin
        busy       = 1'b1;
        clear_done = 1'b0;
        m_addr     = cnt_q;
        m_write    = 1'b0;
        m_data_in  = 1'b0;
        c_data_out = 1'b0;
        unique case (state_q)
            StClear: begin
                m_write    = rst;
                clear_done = rst & last_idx;
            end
            StPass: begin
                busy       = 1'b0;
                m_addr     = c_addr;
                m_write    = c_write & rst;
                m_data_in  = c_data_in;
                c_data_out = m_data_out;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_valid_clear_seq.sv
module tb_valid_clear_seq;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [7:0] c_addr;
    logic       c_write;
    logic       c_data_in;
    logic       c_data_out;
    logic       busy;
    logic       clear_done;
    logic [7:0] m_addr;
    logic       m_write;
    logic       m_data_in;
    logic       m_data_out;

    logic       mem [256];

    int checks = 0;
    int errors = 0;

    valid_clear_seq #(
        .DEPTH (256),
        .ADDR_W(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .c_addr    (c_addr),
        .c_write   (c_write),
        .c_data_in (c_data_in),
        .c_data_out(c_data_out),
        .busy      (busy),
        .clear_done(clear_done),
        .m_addr    (m_addr),
        .m_write   (m_write),
        .m_data_in (m_data_in),
        .m_data_out(m_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Valid-bit memory model: combinational read, write on the rising edge.
    always @(posedge clk) begin
        if (m_write) mem[m_addr] <= m_data_in;
    end
    assign m_data_out = mem[m_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Read through the pass-through path; called at a negedge in PASS.
    task automatic rd(input logic [7:0] addr, input logic exp, input string tag);
        c_addr  = addr;
        c_write = 1'b0;
        #1;
        chk(tag, {31'd0, c_data_out}, {31'd0, exp});
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // Walk a full sweep starting at the current negedge (cnt expected 0).
    // flush_at pulses flush at that index; blk drives a controller write to
    // 8'hFF throughout, which must never reach the memory.
    task automatic sweep(input bit blk, input int flush_at);
        int busy_cycles = 0;
        int pulses      = 0;
        for (int i = 0; i < 256; i++) begin
            if (blk) begin
                c_write   = 1'b1;
                c_addr    = 8'hFF;
                c_data_in = 1'b1;
            end
            flush = (i == flush_at);
            #1;
            chk("sw_addr", {24'd0, m_addr}, i);
            chk("sw_write", {31'd0, m_write}, 32'd1);
            chk("sw_data", {31'd0, m_data_in}, 32'd0);
            chk("sw_cout", {31'd0, c_data_out}, 32'd0);
            chk("sw_done", {31'd0, clear_done}, {31'd0, (i == 255)});
            if (busy) busy_cycles++;
            if (clear_done) pulses++;
            @(posedge clk);
            @(negedge clk);
        end
        flush     = 1'b0;
        c_write   = 1'b0;
        c_data_in = 1'b0;
        #1;
        chk("sw_busy_cycles", busy_cycles, 32'd256);
        chk("sw_pulses", pulses, 32'd1);
        chk("sw_busy_after", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        c_addr    = 8'h00;
        c_write   = 1'b0;
        c_data_in = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_write", {31'd0, m_write}, 32'd0);
        chk("rst_addr", {24'd0, m_addr}, 32'd0);
        chk("rst_done", {31'd0, clear_done}, 32'd0);
        chk("rst_cout", {31'd0, c_data_out}, 32'd0);
        chk("rst_mdata", {31'd0, m_data_in}, 32'd0);
        rst = 1'b1;
        sweep(1'b0, -1);

        // Preload all ones, then reset sweep must clear them
        for (int i = 0; i < 256; i++) mem[i] = 1'b1;
        rd(8'h33, 1'b1, "preload_rd");
        rst = 1'b0;
        #1;
        chk("rst2_write", {31'd0, m_write}, 32'd0);
        chk("rst2_busy", {31'd0, busy}, 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst2_hold_write", {31'd0, m_write}, 32'd0);
        chk("rst2_mem_kept", {31'd0, mem[0]}, 32'd1);
        rst = 1'b1;
        sweep(1'b0, -1);
        rd(8'h00, 1'b0, "clr_rd0");
        rd(8'h7F, 1'b0, "clr_rd127");
        rd(8'hFF, 1'b0, "clr_rd255");

        // Pass-through write then reads
        c_addr    = 8'h5A;
        c_write   = 1'b1;
        c_data_in = 1'b1;
        #1;
        chk("pt_mwrite", {31'd0, m_write}, 32'd1);
        chk("pt_maddr", {24'd0, m_addr}, 32'h5A);
        chk("pt_mdata", {31'd0, m_data_in}, 32'd1);
        chk("pt_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        c_write   = 1'b0;
        c_data_in = 1'b0;
        rd(8'h5A, 1'b1, "pt_rd5a");
        rd(8'h5B, 1'b0, "pt_rd5b");

        // Flush with a coincident write
        flush     = 1'b1;
        c_addr    = 8'h10;
        c_write   = 1'b1;
        c_data_in = 1'b1;
        #1;
        chk("fw_mwrite", {31'd0, m_write}, 32'd1);
        chk("fw_maddr", {24'd0, m_addr}, 32'h10);
        chk("fw_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        flush     = 1'b0;
        c_write   = 1'b0;
        c_data_in = 1'b0;
        chk("fw_landed", {31'd0, mem[8'h10]}, 32'd1);
        chk("fw_busy_next", {31'd0, busy}, 32'd1);
        sweep(1'b0, -1);
        rd(8'h10, 1'b0, "fw_rd10");

        // Flush during sweep at index 100 is ignored
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        sweep(1'b0, 100);

        // Controller write blocked while busy
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        sweep(1'b1, -1);
        rd(8'hFF, 1'b0, "blk_rdff");

        // Reset mid-sweep at index 200
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        chk("mid_addr200", {24'd0, m_addr}, 32'd200);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_write", {31'd0, m_write}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        chk("mid_addr", {24'd0, m_addr}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mid_hold_write", {31'd0, m_write}, 32'd0);
        rst = 1'b1;
        sweep(1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
